// File: rtl/xor_pulse_monitor.sv
// ----------------------------------------------------------------------------
// xor_pulse_monitor
//   Counts edges on the two 1-bit outputs of the registered XOR-select stage
//   over back-to-back measurement windows of WINDOW cycles. Each completed
//   window is offered to a consumer through a valid/ready handshake. If a new
//   window completes while the previous result is still waiting, the new one
//   is dropped and a sticky overrun flag is raised.
//
//   Build option: define XOR_PULSE_BOTH_EDGES_EN to count rising and falling
//   edges. When it is undefined, only rising edges are counted.
//
// Parameters
//   CNT_W   width of each edge counter and result field (>= 2)
//   WINDOW  clock cycles per measurement window (>= 2)
//
// Ports
//   Clock              rising-edge clock
//   Reset              asynchronous, active-high reset
//   Enable_in          high = run windows back to back, low = abort and idle
//   A_xor_in/B_xor_in  monitored lines, already synchronous to Clock
//   Result_ready_in    consumer accepts the result while valid is high
//   Result_valid_out   result fields hold a completed window
//   A_count_out        A edge count of the completed window
//   B_count_out        B edge count of the completed window
//   Overrun_out        sticky, a completed window was discarded
//   Window_active_out  high while the FSM is counting
// ----------------------------------------------------------------------------
module xor_pulse_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable_in,
  input  logic             A_xor_in,
  input  logic             B_xor_in,
  input  logic             Result_ready_in,
  output logic             Result_valid_out,
  output logic [CNT_W-1:0] A_count_out,
  output logic [CNT_W-1:0] B_count_out,
  output logic             Overrun_out,
  output logic             Window_active_out
);

  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_e;

  state_e           state_q;
  logic             prev_a_q, prev_b_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;
  logic [CNT_W-1:0] cnt_a_d, cnt_b_d;
  logic [CNT_W-1:0] res_a_q, res_b_q;
  logic             valid_q, ovr_q, active_q;
  logic             ev_a, ev_b;
  logic             win_last;

  // prev_* track the inputs in every state, so a line that is already high
  // when counting starts does not produce a spurious first edge.
`ifdef XOR_PULSE_BOTH_EDGES_EN
  assign ev_a = A_xor_in ^ prev_a_q;
  assign ev_b = B_xor_in ^ prev_b_q;
`else
  assign ev_a = A_xor_in & ~prev_a_q;
  assign ev_b = B_xor_in & ~prev_b_q;
`endif

  // Saturating increment: a counter at all-ones holds instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic ev);
    return (ev && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  // Next counts include this cycle's events, so an edge on the last window
  // cycle still lands in the completed result.
  assign cnt_a_d  = sat_inc(cnt_a_q, ev_a);
  assign cnt_b_d  = sat_inc(cnt_b_q, ev_b);
  assign win_last = (win_q == WIN_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      prev_a_q <= 1'b0;
      prev_b_q <= 1'b0;
      win_q    <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      res_a_q  <= '0;
      res_b_q  <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      prev_a_q <= A_xor_in;
      prev_b_q <= B_xor_in;

      // Transfer retires the held result; a window completing in this same
      // cycle overrides this below and keeps valid high.
      if (valid_q && Result_ready_in) valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (Enable_in) begin
            state_q  <= S_COUNT;
            active_q <= 1'b1;
            win_q    <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            ovr_q    <= 1'b0;
          end
        end

        S_COUNT: begin
          if (!Enable_in) begin
            // Abort: partial window dropped, pending result left untouched.
            state_q  <= S_IDLE;
            active_q <= 1'b0;
          end else if (win_last) begin
            win_q   <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            if (!valid_q || Result_ready_in) begin
              valid_q <= 1'b1;
              res_a_q <= cnt_a_d;
              res_b_q <= cnt_b_d;
            end else begin
              ovr_q <= 1'b1;
            end
          end else begin
            win_q   <= win_q + WIN_W'(1);
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign Result_valid_out  = valid_q;
  assign A_count_out       = res_a_q;
  assign B_count_out       = res_b_q;
  assign Overrun_out       = ovr_q;
  assign Window_active_out = active_q;

endmodule

// File: doc/xor_pulse_monitor.md
Name: xor_pulse_monitor

Overview:
- Downstream consumer of the registered XOR-select stage's two 1-bit outputs.
- Counts rising edges on each line over fixed measurement windows of WINDOW clock cycles.
- Presents each window's counts through a valid/ready handshake, with overrun detection when the consumer stalls.
- Feeds the status/readout logic that sits after the XOR-select stage.

Parameters:
- CNT_W, 8, width of each edge counter and result field; must be ≥ 2.
- WINDOW, 16, number of clock cycles per measurement window; must be ≥ 2.

Ports:
- Clock  input  1  rising-edge clock shared with the XOR-select stage.
- Reset  input  1  asynchronous, active-high reset.
- Enable_in  input  1  level; high = run back-to-back windows, low = abort and idle.
- A_xor_in  input  1  A_xor_out from upstream; already synchronous to Clock.
- B_xor_in  input  1  B_xor_out from upstream; already synchronous to Clock.
- Result_ready_in  input  1  consumer accepts the result when high while valid is high.
- Result_valid_out  output  1  result fields hold a completed window.
- A_count_out  output  CNT_W  rising-edge count of A for the completed window.
- B_count_out  output  CNT_W  rising-edge count of B for the completed window.
- Overrun_out  output  1  sticky; a completed window was discarded.
- Window_active_out  output  1  high while in COUNT.

Behaviour:
- Single clock Clock; reset Reset is asynchronous and active-high.
- Reset state: FSM = IDLE; prev_a, prev_b, window counter, both live counters and all outputs = 0.
- Edge detect: rise_x = x_in & ~prev_x. prev_x registers x_in every cycle in every state, so an input already high on entry to COUNT is not counted.
- FSM IDLE:
  - Enable_in sampled high → COUNT next cycle.
  - On that transition: clear live counters and the window counter, and clear Overrun_out.
- FSM COUNT:
  - Window cycle k = 0..WINDOW-1 is the k-th cycle in COUNT; a rise_x in any window cycle, including the last, is counted in that window.
  - Live counters saturate at 2^CNT_W-1 and never wrap.
  - When k = WINDOW-1, the final counts (including that cycle's edges) become the completed result. Live counters and the window counter restart at 0, and the next window begins the following cycle with no gap.
  - Enable_in sampled low in any COUNT cycle → IDLE next cycle. The partial window is discarded, no result is produced, and any pending valid result is kept.
- Result latency: Result_valid_out, A_count_out and B_count_out update on the clock edge that ends window cycle WINDOW-1, so they are visible one cycle after that window cycle.
- Handshake:
  - While Result_valid_out=1, A_count_out and B_count_out are stable.
  - A transfer occurs in a cycle with valid=1 and Result_ready_in=1; valid drops the following cycle unless a new result loads.
- Boundary: window completes while valid=1 and ready=0 → new result discarded, old result held, Overrun_out=1 next cycle; it stays set until the next IDLE→COUNT transition or Reset.
- Boundary: window completes in the same cycle as a transfer → old result is accepted, new result loads, valid stays 1, no overrun.
- Boundary: window completes while valid=0 → result loads, valid=1.
- Boundary: Result_ready_in with valid=0 has no effect.
- Window_active_out = (state == COUNT), registered.
- Reset asserted mid-window: everything returns to the reset state immediately; the partial window and any pending result are lost.

Optional Feature:
- Macro: XOR_PULSE_BOTH_EDGES_EN.
- Defined: an event is x_in ^ prev_x, so rising and falling edges are both counted.
- Undefined: rising edges only, as specified above.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset=1 mid-window with A toggling → all outputs 0 asynchronously; after release and Enable_in=1, the first window starts from zero counts.
2. Defaults (CNT_W=8, WINDOW=16), Result_ready_in=1, A=1,0,1,0,… starting window cycle 0 (A=0 before), B held 1 from IDLE → result A=8, B=0; valid pulses for 1 cycle, one cycle after window cycle 15. With XOR_PULSE_BOTH_EDGES_EN defined → A=16, B=0.
3. CNT_W=3, same A toggle stimulus → A_count_out=7 (saturated, no wrap).
4. Result_ready_in=0 for two full windows (first A=3, second A=5) → A_count_out stays 3, Overrun_out=1 one cycle after the second window ends. Raising ready then gives a transfer of 3 and valid=0; Overrun_out stays 1 until the next IDLE→COUNT.
5. Ready asserted exactly in the cycle the second window completes (first A=2, second A=4) → 2 transferred, valid stays 1 with A=4, Overrun_out=0.
6. Enable_in dropped at window cycle 9 with 4 A edges seen → no valid, IDLE one cycle later, Window_active_out=0; a previously pending result is still presented.
